// File: rtl/tail_collector.sv
// tail_collector: gathers a nibble-serial instruction (header + tail nibbles)
// into one parallel word, using the header-length decoder's one-hot result.
// Illegal headers are passed through flagged, and are counted in a saturating counter.
module tail_collector #(
    parameter int MAX_NIBS = 8,
    parameter int TAIL_W   = 4 * (MAX_NIBS - 1),
    parameter int ERRC_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_nib,
    output logic [3:0]        hdr_ir,
    input  logic [3:0]        hdr_len,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_hdr,
    output logic [TAIL_W-1:0] out_tail,
    output logic [2:0]        out_tlen,
    output logic              out_err,
    output logic [ERRC_W-1:0] err_cnt
);

    localparam int NT = MAX_NIBS - 1;

    typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

    state_t               state;
    logic [2:0]           rem;
    logic [NT-1:0][3:0]   tail;
    logic [2:0]           idx;

    // Decoder sees the live stream nibble; it only matters in the header cycle.
    assign hdr_ir    = in_nib;
    // Flush takes priority over a nibble, so it also blocks acceptance.
    assign in_ready  = (state != OUT) && !flush;
    assign out_valid = (state == OUT);
    assign out_tail  = tail;
    // The first tail nibble lands in slot 0, and later nibbles go in increasing slots.
    assign idx       = out_tlen - rem;

    // Control FSM plus header, tail and error-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rem      <= '0;
            tail     <= '0;
            out_hdr  <= '0;
            out_tlen <= '0;
            out_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && in_valid) begin
                        out_hdr <= in_nib;
                        tail    <= '0;
                        out_err <= 1'b0;
                        case (hdr_len)
                            4'b0001: begin
                                out_tlen <= 3'd0;
                                state    <= OUT;
                            end
                            4'b0010: begin
                                out_tlen <= 3'd1;
                                rem      <= 3'd1;
                                state    <= COLLECT;
                            end
                            4'b0100: begin
                                out_tlen <= 3'd3;
                                rem      <= 3'd3;
                                state    <= COLLECT;
                            end
                            4'b1000: begin
                                out_tlen <= 3'd7;
                                rem      <= 3'd7;
                                state    <= COLLECT;
                            end
                            default: begin
                                // Zero or non-one-hot length: deliver the header flagged.
                                out_tlen <= 3'd0;
                                out_err  <= 1'b1;
                                state    <= OUT;
                                if (err_cnt != {ERRC_W{1'b1}})
                                    err_cnt <= err_cnt + 1'b1;
                            end
                        endcase
                    end
                end
                COLLECT: begin
                    if (flush) begin
                        rem   <= '0;
                        state <= IDLE;
                    end else if (in_valid) begin
                        tail[idx] <= in_nib;
                        rem       <= rem - 3'd1;
                        if (rem == 3'd1)
                            state <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_err <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tail_collector.sv
// Randomized and directed bench for tail_collector. An instruction-level scoreboard
// predicts every delivered word from the header/length rules.
module tb_tail_collector;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_nib = '0;
    logic [3:0]  hdr_ir;
    logic [3:0]  hdr_len = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_hdr;
    logic [27:0] out_tail;
    logic [2:0]  out_tlen;
    logic        out_err;
    logic [7:0]  err_cnt;

    tail_collector #(.MAX_NIBS(8), .TAIL_W(28), .ERRC_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_nib(in_nib), .hdr_ir(hdr_ir), .hdr_len(hdr_len), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr),
        .out_tail(out_tail), .out_tlen(out_tlen), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  hdr;
        logic [27:0] tail;
        logic [2:0]  tlen;
        logic        err;
    } instr_t;

    instr_t      expq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_ecnt = 0;
    logic [3:0]  tnib [7];
    bit          rnd_mode = 1'b0;
    bit          manual_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer backpressure: random in the soak phase, otherwise under test control.
    always @(posedge clk) begin
        #1;
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : manual_ready;
    end

    // Output monitor: scoreboard check on each transfer, and a hold check on each stall.
    logic        stall_prev = 1'b0;
    logic [3:0]  p_hdr;
    logic [27:0] p_tail;
    logic [2:0]  p_tlen;
    logic        p_err;
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_tail", out_tail, p_tail);
                chk("hold_hdr", out_hdr, p_hdr);
                chk("hold_tlen", out_tlen, p_tlen);
                chk("hold_err", out_err, p_err);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    instr_t e;
                    e = expq.pop_front();
                    chk("out_hdr", out_hdr, e.hdr);
                    chk("out_tail", out_tail, e.tail);
                    chk("out_tlen", out_tlen, e.tlen);
                    chk("out_err", out_err, e.err);
                    chk("err_cnt", err_cnt, exp_ecnt);
                end
            end
            stall_prev = out_valid && !out_ready;
            p_hdr = out_hdr; p_tail = out_tail; p_tlen = out_tlen; p_err = out_err;
        end
    end

    // Present one nibble and hold it until it is accepted. The task returns at posedge+1.
    task automatic send_nib(input logic [3:0] nib, input logic [3:0] len);
        int t;
        in_valid = 1'b1; in_nib = nib; hdr_len = len;
        for (t = 0; t < 500; t++) begin
            @(negedge clk);
            if (in_ready) begin
                chk("hdr_ir", hdr_ir, nib);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (t == 500) chk("nib_timeout", 0, 1);
        in_valid = 1'b0; hdr_len = 4'($urandom);
    endtask

    // Send a full instruction using the tail nibbles in tnib. Then push the expected word
    // and check that the output appears one cycle after the last nibble.
    task automatic send_instr(input logic [3:0] hdr, input logic [3:0] len, input int gap);
        int     n;
        instr_t e;
        case (len)
            4'b0001: n = 0;
            4'b0010: n = 1;
            4'b0100: n = 3;
            4'b1000: n = 7;
            default: n = -1;
        endcase
        send_nib(hdr, len);
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(posedge clk);
            #0;
            send_nib(tnib[i], 4'($urandom));
        end
        e.hdr  = hdr;
        e.err  = (n < 0);
        e.tlen = (n < 0) ? 3'd0 : 3'(n);
        e.tail = '0;
        for (int i = 0; i < n; i++) e.tail = e.tail + (28'(tnib[i]) << (4 * i));
        if (n < 0 && exp_ecnt < 255) exp_ecnt++;
        expq.push_back(e);
        @(negedge clk);
        chk("latency_valid", out_valid, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] lens [6];
        lens[0] = 4'b0001; lens[1] = 4'b0010; lens[2] = 4'b0100;
        lens[3] = 4'b1000; lens[4] = 4'b0000; lens[5] = 4'b0110;

        // Reset values
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_tail", out_tail, 0);
        chk("rst_tlen", out_tlen, 0);
        chk("rst_hdr", out_hdr, 0);
        chk("rst_err", out_err, 0);
        chk("rst_ecnt", err_cnt, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        manual_ready = 1'b1;
        @(posedge clk); #1;

        // Full-length instruction sent back-to-back
        for (int i = 0; i < 7; i++) tnib[i] = 4'(i + 1);
        send_instr(4'h3, 4'b1000, 0);
        // Length 2 instruction, followed by a header-only instruction
        tnib[0] = 4'hA;
        send_instr(4'h1, 4'b0010, 0);
        send_instr(4'h8, 4'b0001, 0);

        // Illegal headers saturate the counter
        for (int i = 0; i < 300; i++) send_instr(4'h5, 4'b0000, 0);
        chk("err_sat", err_cnt, 255);
        @(posedge clk); #1;

        // Gapped collection, then a 5-cycle output stall
        manual_ready = 1'b0;
        tnib[0] = 4'h9; tnib[1] = 4'h8; tnib[2] = 4'h7;
        send_instr(4'h2, 4'b0100, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_tail", out_tail, 28'h0000789);
        end
        manual_ready = 1'b1;
        repeat (2) @(posedge clk); #1;

        // A flush in the middle of collection drops the partial instruction
        send_nib(4'h3, 4'b1000);
        for (int i = 0; i < 3; i++) send_nib(4'(i + 4), 4'b0000);
        flush = 1'b1; in_valid = 1'b1; in_nib = 4'hF;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_no_out", out_valid, 0);
        @(posedge clk); #1;
        send_instr(4'hC, 4'b0001, 0);

        // Reset asserted mid-collection
        send_nib(4'h3, 4'b1000);
        send_nib(4'h1, 4'b0000);
        send_nib(4'h2, 4'b0000);
        reset_n = 1'b0;
        exp_ecnt = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_tail", out_tail, 0);
        chk("mid_rst_tlen", out_tlen, 0);
        chk("mid_rst_hdr", out_hdr, 0);
        chk("mid_rst_ecnt", err_cnt, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        tnib[0] = 4'h6;
        send_instr(4'hE, 4'b0010, 0);

        // Randomized soak with random backpressure
        rnd_mode = 1'b1;
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 7; i++) tnib[i] = 4'($urandom);
            send_instr(4'($urandom), lens[$urandom_range(0, 5)], $urandom_range(0, 2));
        end
        rnd_mode = 1'b0;
        manual_ready = 1'b1;
        for (int t = 0; t < 50 && expq.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        chk("drain", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tail_collector.md
Name: tail_collector

Overview:
- Downstream neighbour of the header-length decoder (`tail_length`). Consumes a nibble-serial instruction stream and presents the header nibble to the decoder.
- Uses the decoder's one-hot length result to gather the instruction's tail nibbles into one parallel instruction word. The word is handed to the execute stage over a valid/ready interface.
- Flags illegal headers (decoded length of zero) and counts them.

Parameters:
- MAX_NIBS, 8, maximum total instruction length in nibbles including the header. Fixed by the decoder's one-hot width: 1/2/4/8.
- TAIL_W, 28, tail field width = 4*(MAX_NIBS-1).
- ERRC_W, 8, width of the saturating illegal-header counter.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_nib holds a valid stream nibble
- in_ready  out  1  block accepts in_nib this cycle
- in_nib  in  4  stream nibble
- hdr_ir  out  4  nibble driven to the decoder ir input; equals in_nib combinationally
- hdr_len  in  4  decoder len output, one-hot {8,4,2,1} nibbles total, 0 = illegal
- flush  in  1  synchronous discard of any partial instruction
- out_valid  out  1  assembled instruction available
- out_ready  in  1  consumer accepts the instruction
- out_hdr  out  4  header nibble
- out_tail  out  TAIL_W  tail nibbles, first-received nibble in bits [3:0], zero-extended above
- out_tlen  out  3  tail nibble count: 0, 1, 3 or 7
- out_err  out  1  header was illegal
- err_cnt  out  ERRC_W  saturating count of illegal headers

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - out_valid, out_err = 0; out_hdr, out_tail, out_tlen = 0; err_cnt = 0; internal remaining-count = 0.
- A nibble transfers when in_valid & in_ready. An output transfers when out_valid & out_ready.
- in_ready = 1 in IDLE and COLLECT, 0 in OUT.
- out_valid = 1 only in OUT.
- out_* fields are stable while out_valid=1 and out_ready=0.
- IDLE, on nibble transfer (the nibble is the header):
  - Latch out_hdr and clear the tail register.
  - hdr_len=0001 -> OUT next cycle, out_tlen=0.
  - hdr_len=0010/0100/1000 -> COLLECT; remaining = 1/3/7; out_tlen = 1/3/7.
  - hdr_len=0000, or any non-one-hot value -> OUT with out_err=1, out_tlen=0, out_tail=0. err_cnt increments, saturating at all-ones.
- COLLECT:
  - Each nibble transfer writes in_nib into the tail slot at index (out_tlen - remaining), then decrements remaining.
  - The transfer that makes remaining reach 0 moves to OUT next cycle.
  - in_valid=0 stalls with no state change.
  - hdr_len is ignored in this state.
- OUT:
  - On output transfer -> IDLE.
  - out_err clears on leaving OUT.
  - No nibble is accepted in the handshake cycle; the next header is taken the following cycle.
- Latency: out_valid rises the cycle after the final nibble of the instruction transfers (header nibble for length 1).
- Throughput: one instruction per (total nibbles + 1) cycles with no backpressure.
- flush=1:
  - In IDLE/COLLECT: return to IDLE, discard partial tail; no nibble accepted that cycle (in_ready forced 0).
  - In OUT: ignored; the completed instruction is still delivered.
  - err_cnt is unaffected.
- Simultaneous flush and a nibble transfer attempt: flush wins; the nibble is not consumed (in_ready=0).
- Reset mid-COLLECT or mid-OUT: immediate return to reset values; the partial or pending instruction is lost.

Test Plan:
- Header 0011 (len 1000), tail nibbles 1,2,3,4,5,6,7 back-to-back -> out_valid 1 cycle after the 7th, out_tail=28'h7654321, out_tlen=7, out_hdr=3, out_err=0.
- Header 0001 (len 0010), tail A -> out_tail=28'h000000A, out_tlen=1. Then header 1000 (len 0001) -> out_tail=0, out_tlen=0, out_valid 1 cycle after header.
- Header 0101 (len 0000), repeated 300 times with out_ready=1 -> each out_err=1, out_tlen=0; err_cnt saturates at 255.
- Header 0010 (len 0100), tail 9,8,7 with in_valid gaps of 2 cycles, then out_ready=0 for 5 cycles -> out_tail=28'h0000789, held stable and in_ready=0 throughout the stall.
- Header 0011, 3 tail nibbles, then flush=1 -> IDLE. Next header 1100 -> a len-1 instruction with out_tail=0.
- reset_n low for 1 cycle during COLLECT after 2 of 7 tail nibbles -> all outputs 0 immediately; a following clean len-2 instruction assembles correctly.
